// File: rtl/lut_mul_pkg.sv
// lut_mul_pkg: shared encodings for the LUT-slice multiply sequencer
// (op codes, FSM states, legal slice widths, product width).
package lut_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int PROD_W = 64;

  localparam int CHUNK_W_LEGAL [4] = '{2, 4, 8, 16};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic bit chunk_w_legal(int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (CHUNK_W_LEGAL[i] == w) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lut_mul_seq_if.sv
// lut_mul_seq_if: request/response valid-ready bundle of the multiply sequencer.
interface lut_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/lut_mul_seq_slice.sv
// lut_mul_seq_slice: combinational 32 x CHUNK_W LUT multiplier slice.
// Narrow chunks index a full multiple table; wider ones sum nibble lookups.
module lut_mul_seq_slice #(
  parameter int CHUNK_W = 8
) (
  input  logic               resetn,
  input  logic [31:0]        a,
  input  logic [CHUNK_W-1:0] b,
  output logic [31+CHUNK_W:0] p
);
  localparam int P_W = 32 + CHUNK_W;

  logic [P_W-1:0] raw;

  if (CHUNK_W <= 4) begin : g_direct
    logic [P_W-1:0] tbl [2**CHUNK_W];
    always_comb begin
      for (int k = 0; k < 2**CHUNK_W; k++) tbl[k] = P_W'(a) * P_W'(k);
    end
    assign raw = tbl[b];
  end else begin : g_nibble
    localparam int N_NIB = CHUNK_W / 4;
    logic [35:0] tbl [16];
    always_comb begin
      for (int k = 0; k < 16; k++) tbl[k] = 36'(a) * 36'(k);
    end
    always_comb begin
      raw = '0;
      for (int i = 0; i < N_NIB; i++) raw = raw + (P_W'(tbl[b[4*i +: 4]]) << (4*i));
    end
  end

  assign p = resetn ? raw : '0;
endmodule

// File: rtl/lut_mul_seq.sv
// lut_mul_seq: multi-cycle 32x32 multiply walking B through one CHUNK_W-bit LUT slice.
// Define LUT_MUL_EARLY_TERM_EN to leave RUN once the remaining B chunks are all zero.
module lut_mul_seq
  import lut_mul_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  lut_mul_seq_if.slave bus,
  output logic         busy
);
  // state | meaning
  // IDLE  | in_ready high, waiting for a request
  // RUN   | one B chunk per cycle into acc
  // FIX   | apply sign, load out_result
  // DONE  | out_valid high until out_ready

  localparam int N_STEPS = 32 / CHUNK_W;
  localparam int STEP_W  = 5;

  if (!chunk_w_legal(CHUNK_W)) begin : g_bad_chunk_w
    $error("lut_mul_seq: CHUNK_W must be 2, 4, 8 or 16");
  end

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [31:0]         mag_a_q;
  logic [31:0]         mag_b_q;
  logic                neg_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   acc_fix;
  logic [STEP_W-1:0]   step_q;
  logic [31:0]         out_result_q;
  logic [31+CHUNK_W:0] pp;
  logic                a_neg, b_neg, last_chunk;

  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    case (bus.in_op)
      OP_MULH: begin
        a_neg = bus.in_a[31];
        b_neg = bus.in_b[31];
      end
      OP_MULHSU:        a_neg = bus.in_a[31];
      OP_MUL, OP_MULHU: begin end
      default:          begin end
    endcase
  end

  // mag_b_q is shifted down each RUN cycle, so the slice always sees the current chunk at bit 0.
  lut_mul_seq_slice #(.CHUNK_W(CHUNK_W)) u_slice (
    .resetn (1'b1),
    .a      (mag_a_q),
    .b      (mag_b_q[CHUNK_W-1:0]),
    .p      (pp)
  );

`ifdef LUT_MUL_EARLY_TERM_EN
  assign last_chunk = (step_q == STEP_W'(N_STEPS - 1)) || ((mag_b_q >> CHUNK_W) == 32'd0);
`else
  assign last_chunk = (step_q == STEP_W'(N_STEPS - 1));
`endif

  assign acc_fix = neg_q ? (~acc_q + PROD_W'(1)) : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_chunk)    state_d = ST_FIX;
      ST_FIX:                     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= OP_MUL;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      neg_q        <= 1'b0;
      acc_q        <= '0;
      step_q       <= '0;
      out_result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          op_q    <= bus.in_op;
          mag_a_q <= a_neg ? -bus.in_a : bus.in_a;
          mag_b_q <= b_neg ? -bus.in_b : bus.in_b;
          neg_q   <= a_neg ^ b_neg;
          acc_q   <= '0;
          step_q  <= '0;
        end
        ST_RUN: begin
          acc_q   <= acc_q + (PROD_W'(pp) << (CHUNK_W * int'(step_q)));
          step_q  <= step_q + STEP_W'(1);
          mag_b_q <= mag_b_q >> CHUNK_W;
        end
        ST_FIX: begin
          acc_q        <= acc_fix;
          out_result_q <= (op_q == OP_MUL) ? acc_fix[31:0] : acc_fix[63:32];
        end
        default: begin end
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_result = out_result_q;
  assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_lut_mul_seq.sv
// tb_lut_mul_seq: directed checks on a CHUNK_W=8 instance, then a random sweep over all
// slice widths, each scored against a plain-arithmetic model (honours LUT_MUL_EARLY_TERM_EN).
`timescale 1ns/1ps
module tb_lut_mul_seq;
  import lut_mul_pkg::*;

  localparam int NRAND = 1000;

  typedef struct {
    logic [31:0] res;
    int          t_acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0, nvec = 0, nmis = 0, ncmp = 0, done_cnt = 0;
  bit   rand_go = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] ref_mul(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(int w, logic [1:0] op, logic [31:0] b);
    int steps = 32 / w;
`ifdef LUT_MUL_EARLY_TERM_EN
    logic [31:0] m = (op == OP_MULH && b[31]) ? -b : b;
    int k = 1;
    while (k < steps && (m >> (w * k)) != 32'd0) k++;
    steps = k;
`endif
    return steps + 2;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 255));
      4:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- directed instance, CHUNK_W = 8 ----------------
  lut_mul_seq_if bus8();
  logic busy8;
  exp_t q8[$];
  exp_t cur8;
  bit   seen8 = 1'b0;

  lut_mul_seq #(.CHUNK_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave),
    .busy  (busy8)
  );

  always @(negedge clk) begin
    if (reset) seen8 = 1'b0;
    else if (bus8.out_valid) begin
      if (!seen8) begin
        if (q8.size() == 0) begin
          ncmp++; nmis++;
          $display("FAIL w8_unexpected: out_valid with result %h, required no output", bus8.out_result);
        end else begin
          cur8 = q8.pop_front();
          chk("w8_result", bus8.out_result, cur8.res);
          chk("w8_latency", cyc - cur8.t_acc, cur8.lat);
        end
        seen8 = 1'b1;
      end else chk("w8_hold", bus8.out_result, cur8.res);
      if (bus8.out_ready) seen8 = 1'b0;
    end
  end

  task automatic issue8(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    bit ok = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    bus8.in_op = op; bus8.in_a = a; bus8.in_b = b; bus8.in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus8.in_ready;
    end
    if (ok) begin
      e.res = ref_mul(op, a, b); e.t_acc = cyc; e.lat = ref_lat(8, op, b);
      q8.push_back(e);
      nvec++;
    end else begin
      nmis++;
      $display("FAIL w8_accept: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    bus8.in_valid = 1'b0; bus8.in_a = $urandom; bus8.in_b = $urandom;
  endtask

  task automatic drain8();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (q8.size() == 0) && bus8.in_ready;
    end
    if (!ok) begin
      nmis++;
      $display("FAIL w8_drain: %0d results still pending, required 0", q8.size());
    end
  endtask

  // ---------------- random sweep, one instance per slice width ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    localparam int W = 2 << gi;
    lut_mul_seq_if bus();
    logic busy;
    exp_t q[$];
    exp_t cur;
    bit   seen = 1'b0;
    bit   drv_done = 1'b0;

    lut_mul_seq #(.CHUNK_W(W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .busy  (busy)
    );

    always @(negedge clk) begin
      if (reset) seen = 1'b0;
      else if (bus.out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            ncmp++; nmis++;
            $display("FAIL w%0d_unexpected: out_valid with result %h, required no output", W, bus.out_result);
          end else begin
            cur = q.pop_front();
            chk($sformatf("w%0d_result", W), bus.out_result, cur.res);
            chk($sformatf("w%0d_latency", W), cyc - cur.t_acc, cur.lat);
          end
          seen = 1'b1;
        end else chk($sformatf("w%0d_hold", W), bus.out_result, cur.res);
        if (bus.out_ready) seen = 1'b0;
      end
    end

    initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      bit          ok;
      exp_t        e;
      bus.in_valid = 1'b0; bus.in_op = OP_MUL; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
      wait (rand_go);
      fork
        begin
          for (int n = 0; n < NRAND; n++) begin
            op = 2'($urandom_range(0, 3)); a = rnd32(); b = rnd32();
            @(posedge clk); #1;
            bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
              @(negedge clk);
              ok = bus.in_ready;
            end
            if (!ok) begin
              nmis++;
              $display("FAIL w%0d_accept: in_ready stayed 0, required 1", W);
              break;
            end
            e.res = ref_mul(op, a, b); e.t_acc = cyc; e.lat = ref_lat(W, op, b);
            q.push_back(e);
            nvec++;
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
          end
          drv_done = 1'b1;
        end
        begin
          while (!drv_done) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
          end
          bus.out_ready = 1'b1;
        end
      join
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        ok = (q.size() == 0) && !bus.out_valid;
      end
      if (!ok) begin
        nmis++;
        $display("FAIL w%0d_drain: %0d results still pending, required 0", W, q.size());
      end
      done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  vec_t dv [11];

  initial begin
    int  n_rdy_lo, n_ov;
    bit  ok;
    dv = '{
      '{OP_MUL,    32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
      '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
      '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
      '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{OP_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF},
      '{OP_MULH,   32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
      '{OP_MUL,    32'h1234_5678, 32'h0000_0003, 32'h369D_0368},
      '{OP_MUL,    32'h1234_5678, 32'h0100_0000, 32'h7800_0000},
      '{OP_MULH,   32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000}
    };
    bus8.in_valid = 1'b0; bus8.in_op = OP_MUL; bus8.in_a = '0; bus8.in_b = '0; bus8.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus8.in_ready), 1);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_out_valid", 32'(bus8.out_valid), 0);
    chk("rst_out_result", bus8.out_result, 0);
    reset = 1'b0;

    // latency window of a single MUL with out_ready held high
    issue8(OP_MUL, 32'd7, 32'd6);
    n_rdy_lo = 0; n_ov = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus8.in_ready) n_rdy_lo++;
      if (bus8.out_valid) n_ov++;
    end
    chk("t1_in_ready_low_cycles", n_rdy_lo, ref_lat(8, OP_MUL, 32'd6));
    chk("t1_valid_pulse_cycles", n_ov, 1);
    chk("t1_result_kept", bus8.out_result, 32'h0000_002A);

    for (int i = 0; i < 11; i++) begin
      issue8(dv[i].op, dv[i].a, dv[i].b);
      drain8();
      chk($sformatf("vec%0d_result", i), bus8.out_result, dv[i].r);
    end

    // backpressure in DONE with ignored in_valid pulses
    bus8.out_ready = 1'b0;
    issue8(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus8.out_valid;
    end
    if (!ok) begin
      nmis++;
      $display("FAIL t4_out_valid: out_valid stayed 0, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_valid_held", 32'(bus8.out_valid), 1);
      chk("t4_in_ready", 32'(bus8.in_ready), 0);
      chk("t4_result_stable", bus8.out_result, ref_mul(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
      @(posedge clk); #1;
      bus8.in_valid = (i < 4) ? ~bus8.in_valid : 1'b0;
      bus8.in_a = $urandom;
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_before_release", 32'(bus8.out_valid), 1);
    @(negedge clk);
    chk("t4_valid_after_release", 32'(bus8.out_valid), 0);
    chk("t4_idle_after_release", 32'(bus8.in_ready), 1);
    @(negedge clk);
    chk("t4_no_extra_accept", 32'(busy8), 0);

    // asynchronous reset in the second RUN cycle
    issue8(OP_MUL, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t5_out_valid", 32'(bus8.out_valid), 0);
    chk("t5_busy", 32'(busy8), 0);
    chk("t5_in_ready", 32'(bus8.in_ready), 1);
    chk("t5_out_result", bus8.out_result, 0);
    q8.delete();
    seen8 = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    issue8(OP_MUL, 32'd3, 32'd5);
    drain8();
    chk("t5_after_reset", bus8.out_result, 32'h0000_000F);

    rand_go = 1'b1;
    for (int i = 0; i < 90000 && done_cnt < 4; i++) @(posedge clk);
    if (done_cnt < 4) begin
      nmis++;
      $display("FAIL sweep_timeout: %0d widths finished, required 4", done_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/lut_mul_seq.md
Name: lut_mul_seq

Overview:
Multi-cycle 32x32 multiply sequencer built around one shared LUT multiplier slice of width CHUNK_W.
- Latches operands on a valid/ready handshake and converts signed operands to magnitudes.
- Walks operand B one CHUNK_W-bit chunk per cycle through the slice, accumulating shifted partial products into a 64-bit register.
- Applies the sign fix-up, then returns the low or high 32 bits on a valid/ready output handshake.
- Serves as the multiply unit behind the core's M-extension decode, trading latency for a single small slice.

Parameters:
CHUNK_W, 8, B bits consumed per cycle; legal values 2, 4, 8, 16; any other value is a elaboration error.
N_STEPS, 32/CHUNK_W, derived localparam, number of RUN cycles without early termination.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE
in_op  in  2  00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
in_a  in  32  operand A (rs1)
in_b  in  32  operand B (rs2)
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_result  out  32  MUL: product[31:0]; others: product[63:32]
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous and effective immediately, including mid-operation:
  - state=IDLE, acc=0, step=0, neg=0, out_valid=0, out_result=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid (acceptance cycle t), latch the following, then go to RUN:
    - op.
    - mag_a = |in_a| if A is signed (MULH, MULHSU) else in_a.
    - mag_b = |in_b| if B is signed (MULH) else in_b.
    - neg = sign_a XOR sign_b, with signs taken only for signed operands.
    - acc=0, step=0.
- RUN:
  - Each cycle: acc <= acc + (slice(mag_a, mag_b chunk[step]) << (CHUNK_W*step)), then step++.
  - Slice output is 32+CHUNK_W bits, zero-extended to 64; the sum is truncated to 64 bits and can never overflow.
  - After step N_STEPS-1, go to FIX.
- FIX (1 cycle):
  - acc <= neg ? (~acc + 1) : acc.
  - Then load out_result from acc per op, go to DONE with out_valid=1.
- Latency: out_valid first high in cycle t+N_STEPS+2 (t+6 for CHUNK_W=8).
- DONE:
  - out_valid=1; out_result stays stable until out_ready.
  - On out_valid & out_ready, go to IDLE next cycle with out_valid=0; out_result keeps its last value.
  - No same-cycle re-accept: in_ready=0 in DONE.
- in_valid outside IDLE is ignored (not accepted). Input changes after acceptance are ignored.
- Magnitude of 0x80000000 is 2^31 and fits unsigned 32 bits. MULH 0x80000000*0x80000000 gives 2^62, positive.
- Zero operand: the result is 0 and neg is irrelevant, because the 64-bit negation of 0 is 0.
- The slice's own resetn input is tied to 1; sequencing and reset are owned here.

Optional Feature:
Macro LUT_MUL_EARLY_TERM_EN.
- Defined:
  - After processing chunk k, if mag_b >> (CHUNK_W*(k+1)) == 0, go to FIX directly.
  - Latency is t+K+2, where K (>=1) is the number of chunks processed.
  - b=0 or b<2^CHUNK_W gives t+3.
- Undefined: always N_STEPS RUN cycles; fixed latency t+N_STEPS+2.

Decomposition:
- Package lut_mul_pkg holds:
  - op encoding constants OP_MUL/OP_MULH/OP_MULHSU/OP_MULHU.
  - FSM state encoding.
  - the legal CHUNK_W set.
  - a PROD_W=64 constant.
- One sub-module: the existing LUT multiplier slice matching CHUNK_W (2b/4b/8b/16b), selected by generate on CHUNK_W.
- Sign conversion, accumulator and FSM stay in lut_mul_seq.

Test Plan:
1. CHUNK_W=8, MUL a=7 b=6, out_ready=1 -> out_result=0x0000002A; out_valid exactly 6 cycles after acceptance, 1-cycle pulse; in_ready low 6 cycles.
2. a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MUL -> 0x00000001; MULHSU -> 0xFFFFFFFF; MULH (-1*-1) -> 0x00000000.
3. MULH 0x80000000*0x80000000 -> 0x40000000; MULH 0xFFFFFFFF*0x00000001 -> 0xFFFFFFFF; MULH 0x80000000*0x00000001 -> 0xFFFFFFFF.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_result stable; in_valid pulses are not accepted; release -> IDLE next cycle.
5. Assert reset in 2nd RUN cycle -> out_valid=0, busy=0, in_ready=1 without waiting for clk; next MUL 3*5 -> 0x0000000F.
6. LUT_MUL_EARLY_TERM_EN, CHUNK_W=8: MUL a=0x12345678 b=3 -> 0x369D0368 at t+3; b=0x01000000 -> t+6. Without the macro, both at t+6. Sweep all CHUNK_W values with 1000 random ops against a reference model.
